alu_issue: RTL

Command front-end for the 16-bit ALU. Accepts operand/opcode commands over a valid/ready handshake and queues them in a small FIFO. Issues one command at a time on registered, stable ALU inputs, waits a fixed settle time, then captures and masks the ALU result. The result is returned over a second valid/ready handshake. Sits directly upstream of the ALU (drives `a`, `b`, `en`) and also collects its `kq`/`carry`/`so_du` outputs.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_issue_if.sv | 39 +++
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_issue.sv | 123 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front-end: opcodes, FSM state encoding,
// command layout and a legality helper.
package alu_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;

   // {a, b, op}
   localparam int CMD_W = 35;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  op;
   } cmd_t;

   function automatic logic op_legal(input logic [2:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_XOR: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Command and result handshakes of the ALU front-end; master is the upstream/downstream
// user, slave is alu_issue. out_err exists only with `ALU_ISSUE_ERR_EN.
interface alu_issue_if;

   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [2:0]  in_op;

   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_kq;
   logic        out_carry;
   logic [8:0]  out_du;
   logic [2:0]  out_op;
`ifdef ALU_ISSUE_ERR_EN
   logic        out_err;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_kq, out_carry, out_du, out_op, out_err
   );
   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_kq, out_carry, out_du, out_op, out_err
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_kq, out_carry, out_du, out_op
   );
   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_kq, out_carry, out_du, out_op
   );
`endif

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for alu_issue: DEPTH entries (power of two), show-ahead read so rdata
// is the head entry in the same cycle pop is asserted.
module alu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 35
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rdata = mem[rd_ptr_reg];
   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/alu_issue.sv
// ALU command front-end: queues commands, holds them on registered ALU inputs for
// SETTLE_CYC cycles, then captures a masked result. `ALU_ISSUE_ERR_EN adds out_err.
module alu_issue
   import alu_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int SETTLE_CYC = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_issue_if.slave  bus,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_en,
   input  logic [15:0] alu_kq,
   input  logic        alu_carry,
   input  logic [8:0]  alu_du
);
   localparam int CNTW = $clog2(DEPTH) + 1;
   localparam int SW   = $clog2(SETTLE_CYC + 1);
   localparam logic [CNTW-1:0] FULL_CNT    = CNTW'(DEPTH);
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(SETTLE_CYC);

   state_t           state_reg;
   logic [SW-1:0]    cnt_reg;
   logic [CMD_W-1:0] fifo_wdata;
   logic [CMD_W-1:0] fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNTW-1:0]  fifo_count;
   logic             push;
   logic             pop;
   cmd_t             head;
   logic [15:0]      cap_kq;
   logic             cap_carry;
   logic [8:0]       cap_du;

   assign bus.in_ready = (fifo_count != FULL_CNT);
   assign push         = bus.in_valid && !fifo_full;
   assign fifo_wdata   = {bus.in_a, bus.in_b, bus.in_op};
   assign head         = cmd_t'(fifo_rdata);

   // Pop from IDLE, or from HOLD when the current result is being accepted.
   assign pop = !fifo_empty &&
                ((state_reg == ST_IDLE) || (state_reg == ST_HOLD && bus.out_ready));

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // The ALU leaves carry/so_du stale for ops that do not produce them.
   always_comb begin
      cap_kq    = 16'h0000;
      cap_carry = 1'b0;
      cap_du    = 9'h000;
      if (op_legal(alu_en))                      cap_kq    = alu_kq;
      if (alu_en == OP_ADD || alu_en == OP_SUB)  cap_carry = alu_carry;
      if (alu_en == OP_DIV)                      cap_du    = alu_du;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         alu_a         <= 16'h0000;
         alu_b         <= 16'h0000;
         alu_en        <= 3'd0;
         bus.out_valid <= 1'b0;
         bus.out_kq    <= 16'h0000;
         bus.out_carry <= 1'b0;
         bus.out_du    <= 9'h000;
         bus.out_op    <= 3'd0;
`ifdef ALU_ISSUE_ERR_EN
         bus.out_err   <= 1'b0;
`endif
      end else begin
         if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_en  <= head.op;
            cnt_reg <= SETTLE_LOAD;
         end
         case (state_reg)
            ST_IDLE: begin
               if (pop) state_reg <= ST_SETTLE;
            end
            ST_SETTLE: begin
               cnt_reg <= cnt_reg - 1'b1;
               if (cnt_reg == SW'(1)) begin
                  bus.out_valid <= 1'b1;
                  bus.out_kq    <= cap_kq;
                  bus.out_carry <= cap_carry;
                  bus.out_du    <= cap_du;
                  bus.out_op    <= alu_en;
`ifdef ALU_ISSUE_ERR_EN
                  bus.out_err   <= !op_legal(alu_en);
`endif
                  state_reg     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state_reg     <= pop ? ST_SETTLE : ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule
